imem_load_ctrl: RTL and testbench

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Loads a program into instruction memory from a byte stream. The CPU fetch
// stage is held off while a load is in progress.
//
// Bytes are packed MSB-first into LEN_WORD-bit words. Each completed word is
// written to instruction memory on the cycle after its last byte arrives.
// The stream can run at one byte per cycle with no bubbles.
//
// Optional feature (compile-time macro IMEM_LOAD_CTRL_CLEAR_EN):
//   When defined, the words above the loaded program (addresses load_len up
//   to SIZE_MEM-1) are zero-filled after the load, one word per cycle.
//   When undefined, the CLEAR state and its logic do not exist.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   load_start  single-cycle request to begin a load (acted on in IDLE only)
//   load_len    number of words to load, sampled with load_start
//   in_valid    byte-stream valid
//   in_data     program byte
//   in_ready    a byte is accepted on any cycle with in_valid & in_ready
//   mem_we      instruction-memory write strobe
//   mem_waddr   instruction-memory word address
//   mem_wdata   instruction-memory write data
//   cpu_stall   high in every state except IDLE
//   done        one-cycle pulse when the load (and clear, if present) ends
//   err         sticky flag; set by a request with load_len > SIZE_MEM
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int LEN_WORD = 32,
  parameter int SIZE_MEM = 256,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic [ADDR_W:0]     load_len,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [LEN_WORD-1:0] mem_wdata,
  output logic                cpu_stall,
  output logic                done,
  output logic                err
);

  localparam int BYTES = LEN_WORD / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_W:0] SIZE_L    = (ADDR_W + 1)'(SIZE_MEM);
`ifdef IMEM_LOAD_CTRL_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE_MEM - 1);
`endif

`ifdef IMEM_LOAD_CTRL_CLEAR_EN
  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [ADDR_W:0]      len_q, len_d;
  // Word counter doubles as the zero-fill address while clearing.
  logic [ADDR_W-1:0]    word_q, word_d;
  logic [BCW-1:0]       byte_q, byte_d;
  // Holds the first BYTES-1 bytes of the current word; the last byte is
  // appended directly from in_data when the word is written.
  logic [LEN_WORD-9:0]  asm_q, asm_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [LEN_WORD-1:0]  wdata_q, wdata_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    byte_d  = byte_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_len == '0) begin
            word_d  = '0;
`ifdef IMEM_LOAD_CTRL_CLEAR_EN
            state_d = CLEAR;
`else
            state_d = DONE;
`endif
          end else if (load_len <= SIZE_L) begin
            len_d   = load_len;
            word_d  = '0;
            byte_d  = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        // in_ready is constant 1 here, so in_valid alone marks acceptance.
        if (in_valid) begin
          if (byte_q == LAST_BYTE) begin
            byte_d  = '0;
            we_d    = 1'b1;
            waddr_d = word_q;
            wdata_d = {asm_q, in_data};
            if ({1'b0, word_q} == len_q - 1'b1) begin
`ifdef IMEM_LOAD_CTRL_CLEAR_EN
              if (len_q == SIZE_L) begin
                state_d = DONE;
              end else begin
                word_d  = word_q + 1'b1;
                state_d = CLEAR;
              end
`else
              state_d = DONE;
`endif
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            byte_d = byte_q + 1'b1;
            asm_d  = {asm_q[LEN_WORD-17:0], in_data};
          end
        end
      end

`ifdef IMEM_LOAD_CTRL_CLEAR_EN
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = word_q;
        wdata_d = '0;
        if (word_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          word_d = word_q + 1'b1;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign cpu_stall = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
//
// Self-checking bench for imem_load_ctrl (SIZE_MEM = 8, 32-bit words).
// Expected writes come from a word-level model: word w of a load is bytes
// 4w..4w+3 packed big-endian, followed (when IMEM_LOAD_CTRL_CLEAR_EN is
// defined) by zero words for every address above the program. A model memory
// image is compared with the image built from observed writes.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam int LEN_WORD = 32;
  localparam int SIZE_MEM = 8;
  localparam int ADDR_W   = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                load_start;
  logic [ADDR_W:0]     load_len;
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [LEN_WORD-1:0] mem_wdata;
  logic                cpu_stall;
  logic                done;
  logic                err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_load_ctrl #(
    .LEN_WORD (LEN_WORD),
    .SIZE_MEM (SIZE_MEM),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wr_log[$];
  wr_t         exp_q[$];
  int          done_cyc[$];
  logic [7:0]  stim[$];
  logic [31:0] obs_mem [SIZE_MEM];
  logic [31:0] ref_mem [SIZE_MEM];
  int          cyc_n        = 0;
  int          stall_cycles = 0;
  int          stall_bad    = 0;
  int          acc_cycles;
  logic        ready_after;

  initial begin
    for (int a = 0; a < SIZE_MEM; a++) begin
      obs_mem[a] = '0;
      ref_mem[a] = '0;
    end
  end

  // Observer: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (mem_we) begin
      wr_log.push_back('{int'(mem_waddr), mem_wdata, cyc_n});
      obs_mem[mem_waddr] <= mem_wdata;
    end
    if (done) done_cyc.push_back(cyc_n);
    if (cpu_stall) stall_cycles <= stall_cycles + 1;
    if ((mem_we || in_ready || done) && !cpu_stall) stall_bad <= stall_bad + 1;
  end

  // Word-level reference: program words, then zero-fill when clearing exists.
  function automatic void build_exp(input int len);
    exp_q.delete();
    for (int w = 0; w < len; w++)
      exp_q.push_back('{w, {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]}, 0});
`ifdef IMEM_LOAD_CTRL_CLEAR_EN
    for (int a = len; a < SIZE_MEM; a++)
      exp_q.push_back('{a, 32'h0, 0});
`endif
    foreach (exp_q[i]) ref_mem[exp_q[i].addr] = exp_q[i].data;
  endfunction

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random valid.
  task automatic drive_load(input int len, input int nbytes, input int mode,
                            input bit spurious, input bit wait_done);
    int idx = 0;
    int cyc = 0;
    int n   = 0;
    bit v;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = (ADDR_W + 1)'(len);
    @(negedge clk);
    load_start = 1'b0;
    while (idx < nbytes && cyc < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      load_start = spurious && (cyc == 3);
      if (spurious && cyc == 3) load_len = 4'd15;
      in_valid = v;
      in_data  = v ? stim[idx] : 8'($urandom);
      if (v && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    load_start  = 1'b0;
    in_valid    = 1'b0;
    acc_cycles  = cyc;
    ready_after = in_ready;
    if (wait_done) begin
      while (done_cyc.size() == 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      repeat (3) @(negedge clk);
    end
    $display("load len=%0d bytes=%0d mode=%0d cycles=%0d writes=%0d",
             len, nbytes, mode, cyc, wr_log.size());
  endtask

  task automatic test_reset;
    reset = 1'b1; load_start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_waddr, mem_wdata, cpu_stall, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b we=%b addr=%0d data=%h stall=%b done=%b err=%b want all 0",
               in_ready, mem_we, mem_waddr, mem_wdata, cpu_stall, done, err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got stall=%b ready=%b want 0 0", cpu_stall, in_ready);
    end
  endtask

  task automatic test_directed;
    for (int m = 0; m < 2; m++) begin
      int sb;
      stim = '{8'h20, 8'h08, 8'h00, 8'h06, 8'h01, 8'h00, 8'h80, 8'h20};
      wr_log.delete(); done_cyc.delete();
      sb = stall_bad;
      build_exp(2);
      drive_load(2, 8, m, 1'b0, 1'b1);
      checks++;
      if (wr_log.size() < 2 || wr_log[0].addr != 0 || wr_log[0].data !== 32'h20080006) begin
        errors++;
        $display("FAIL dir_word0 mode=%0d got %h@%0d want 20080006@0", m,
                 (wr_log.size() > 0) ? wr_log[0].data : 32'hx,
                 (wr_log.size() > 0) ? wr_log[0].addr : -1);
      end
      checks++;
      if (wr_log.size() < 2 || wr_log[1].addr != 1 || wr_log[1].data !== 32'h01008020) begin
        errors++;
        $display("FAIL dir_word1 mode=%0d got %h@%0d want 01008020@1", m,
                 (wr_log.size() > 1) ? wr_log[1].data : 32'hx,
                 (wr_log.size() > 1) ? wr_log[1].addr : -1);
      end
      checks++;
      if (wr_log.size() != exp_q.size()) begin
        errors++;
        $display("FAIL dir_write_count mode=%0d got %0d want %0d", m, wr_log.size(), exp_q.size());
      end
      checks++;
      if (done_cyc.size() != 1) begin
        errors++;
        $display("FAIL dir_done_pulses mode=%0d got %0d want 1", m, done_cyc.size());
      end
      checks++;
      if (acc_cycles != ((m == 0) ? 8 : 15)) begin
        errors++;
        $display("FAIL dir_byte_cycles mode=%0d got %0d want %0d", m, acc_cycles, (m == 0) ? 8 : 15);
      end
      checks++;
      if (stall_bad != sb) begin
        errors++;
        $display("FAIL dir_stall mode=%0d got %0d unstalled active cycles want 0", m, stall_bad - sb);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      int len;
      int mode;
      int sb;
      len  = (it == 0) ? SIZE_MEM : (it == 1) ? 0 : $urandom_range(1, SIZE_MEM);
      mode = it % 3;
      stim.delete();
      for (int b = 0; b < 4 * len; b++) stim.push_back(8'($urandom));
      wr_log.delete(); done_cyc.delete();
      sb = stall_bad;
      build_exp(len);
      drive_load(len, 4 * len, mode, 1'b0, 1'b1);
      checks++;
      if (wr_log.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_write_count len=%0d got %0d want %0d", len, wr_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
        checks++;
        if (wr_log[i].addr != exp_q[i].addr || wr_log[i].data !== exp_q[i].data) begin
          errors++;
          $display("FAIL rand_write len=%0d idx=%0d got %h@%0d want %h@%0d", len, i,
                   wr_log[i].data, wr_log[i].addr, exp_q[i].data, exp_q[i].addr);
        end
      end
      for (int i = (len > 0) ? len : 1; i < wr_log.size(); i++) begin
        checks++;
        if (wr_log[i].cyc != wr_log[i-1].cyc + 1) begin
          errors++;
          $display("FAIL clear_consecutive idx=%0d got cycle %0d want %0d", i,
                   wr_log[i].cyc, wr_log[i-1].cyc + 1);
        end
      end
      checks++;
      if (done_cyc.size() != 1) begin
        errors++;
        $display("FAIL rand_done_pulses len=%0d got %0d want 1", len, done_cyc.size());
      end
      if (done_cyc.size() == 1 && wr_log.size() > 0) begin
        checks++;
        if (done_cyc[0] < wr_log[wr_log.size()-1].cyc || done_cyc[0] > wr_log[wr_log.size()-1].cyc + 1) begin
          errors++;
          $display("FAIL rand_done_timing len=%0d got done cycle %0d want %0d or next", len,
                   done_cyc[0], wr_log[wr_log.size()-1].cyc);
        end
      end
      if (len > 0) begin
        checks++;
        if (ready_after !== 1'b0) begin
          errors++;
          $display("FAIL ready_drop len=%0d got %b want 0", len, ready_after);
        end
      end
      if (mode == 0) begin
        checks++;
        if (acc_cycles != 4 * len) begin
          errors++;
          $display("FAIL no_bubbles len=%0d got %0d cycles want %0d", len, acc_cycles, 4 * len);
        end
      end
      checks++;
      if (stall_bad != sb) begin
        errors++;
        $display("FAIL rand_stall len=%0d got %0d unstalled active cycles want 0", len, stall_bad - sb);
      end
      for (int a = 0; a < SIZE_MEM; a++) begin
        checks++;
        if (obs_mem[a] !== ref_mem[a]) begin
          errors++;
          $display("FAIL rand_mem addr=%0d got %h want %h", a, obs_mem[a], ref_mem[a]);
        end
      end
    end
  endtask

  task automatic test_error_ignore;
    int sc;
    stim = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h12, 8'h34, 8'h56, 8'h78};
    wr_log.delete(); done_cyc.delete();
    build_exp(2);
    drive_load(2, 8, 0, 1'b1, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL ignore_err got %b want 0", err);
    end
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ignore_write_count got %0d want %0d", wr_log.size(), exp_q.size());
    end
    checks++;
    if (wr_log.size() < 2 || wr_log[1].data !== 32'h12345678 || wr_log[1].addr != 1) begin
      errors++;
      $display("FAIL ignore_word1 got %h want 12345678@1", (wr_log.size() > 1) ? wr_log[1].data : 32'hx);
    end
    checks++;
    if (done_cyc.size() != 1) begin
      errors++;
      $display("FAIL ignore_done got %0d want 1", done_cyc.size());
    end
    wr_log.delete(); done_cyc.delete();
    sc = stall_cycles;
    drive_load(9, 0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b want 1", err);
    end
    checks++;
    if (wr_log.size() != 0 || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL err_no_activity got writes=%0d done=%0d want 0 0", wr_log.size(), done_cyc.size());
    end
    checks++;
    if (stall_cycles != sc) begin
      errors++;
      $display("FAIL err_stall got %0d stalled cycles want 0", stall_cycles - sc);
    end
  endtask

  task automatic test_reset_midword;
    logic [31:0] w0;
    stim = '{8'h20, 8'h08, 8'h00, 8'h06, 8'h01, 8'h00, 8'h80, 8'h20};
    wr_log.delete(); done_cyc.delete();
    drive_load(2, 6, 0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_waddr, mem_wdata, cpu_stall, done, err} !== '0) begin
      errors++;
      $display("FAIL midword_reset got ready=%b we=%b addr=%0d data=%h stall=%b done=%b err=%b want all 0",
               in_ready, mem_we, mem_waddr, mem_wdata, cpu_stall, done, err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (wr_log.size() != 1 || wr_log[0].data !== 32'h20080006) begin
      errors++;
      $display("FAIL midword_writes got count=%0d want 1 write of 20080006", wr_log.size());
    end
    ref_mem[0] = 32'h20080006;
    stim.delete();
    for (int b = 0; b < 4; b++) stim.push_back(8'($urandom));
    w0 = {stim[0], stim[1], stim[2], stim[3]};
    wr_log.delete(); done_cyc.delete();
    build_exp(1);
    drive_load(1, 4, 2, 1'b0, 1'b1);
    checks++;
    if (wr_log.size() == 0 || wr_log[0].addr != 0 || wr_log[0].data !== w0) begin
      errors++;
      $display("FAIL after_reset_word got %h want %h@0", (wr_log.size() > 0) ? wr_log[0].data : 32'hx, w0);
    end
    for (int a = 0; a < SIZE_MEM; a++) begin
      checks++;
      if (obs_mem[a] !== ref_mem[a]) begin
        errors++;
        $display("FAIL after_reset_mem addr=%0d got %h want %h", a, obs_mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_error_ignore();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
